// File: rtl/pezaris_div_pkg.sv
// pezaris_div_pkg
// Shared definitions for the Pezaris sequential divider: the controller
// state encoding, the default operand width and the iteration-counter
// width helper.
package pezaris_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 7;

  // Bits needed to count from WIDTH down to 1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pezaris_seq_divider_sub_row.sv
// div_sub_row
// One restoring-division row: compare the shifted partial remainder with
// the divisor magnitude and subtract when it fits.
// Ports:
//   p_i  [WIDTH:0]   shifted partial remainder
//   d_i  [WIDTH-1:0] divisor magnitude (non-zero)
//   p_o  [WIDTH-1:0] next partial remainder (always < d_i, so WIDTH bits suffice)
//   q_o              quotient bit for this row
module div_sub_row #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);

  logic [WIDTH:0] diff_s;

  assign diff_s = p_i - {1'b0, d_i};
  // The previous remainder is below d_i, so p_i < 2*d_i: the difference
  // has its top bit clear exactly when p_i >= d_i.
  assign q_o    = ~diff_s[WIDTH];
  assign p_o    = q_o ? diff_s[WIDTH-1:0] : p_i[WIDTH-1:0];

endmodule

// File: rtl/pezaris_seq_divider.sv
// pezaris_seq_divider
// Iterative signed two's-complement divider (restoring, one quotient bit
// per cycle). Quotient truncates toward zero, remainder follows the sign
// of the dividend. Divide-by-zero returns -1 r dividend with div_by_zero;
// -2^(WIDTH-1) / -1 wraps and raises overflow.
// Optional build macro: PEZARIS_DIV_FAST_PATH_EN -- a zero dividend or a
// divisor of magnitude 1 skips the iteration phase (same results).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, sampled while ready
//   dividend, divisor   signed operands captured on accepted start
//   ready, busy         idle / operation in progress
//   done                one-cycle pulse when results are valid
//   quotient, remainder signed results, held until next result
//   div_by_zero, overflow flags for the last result
module pezaris_seq_divider
  import pezaris_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic             neg_n_q, neg_n_d;
  logic             neg_d_q, neg_d_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dvd_mag_s, dsr_mag_s, row_p_s;
  logic             row_q_s, fast_s;

  assign dvd_mag_s = dividend[WIDTH-1] ? (W_ZERO - dividend) : dividend;
  assign dsr_mag_s = divisor[WIDTH-1]  ? (W_ZERO - divisor)  : divisor;

`ifdef PEZARIS_DIV_FAST_PATH_EN
  // Trivial operands: the captured magnitude already is the quotient magnitude.
  assign fast_s = (dividend == W_ZERO) || (dsr_mag_s == W_ONE);
`else
  assign fast_s = 1'b0;
`endif

  div_sub_row #(.WIDTH(WIDTH)) u_row (
    .p_i ({1'b0, p_q, acc_q[WIDTH-1]}),
    .d_i (dsr_q),
    .p_o (row_p_s),
    .q_o (row_q_s)
  );

  // Next-state and datapath update for the IDLE/CALC/FIX controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    neg_n_d = neg_n_q;
    neg_d_d = neg_d_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_n_d = dividend[WIDTH-1];
          neg_d_d = divisor[WIDTH-1];
          acc_d   = dvd_mag_s;
          dsr_d   = dsr_mag_s;
          p_d     = W_ZERO;
          cnt_d   = CNT_INIT;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = (dsr_mag_s == W_ZERO);
          if ((dsr_mag_s == W_ZERO) || fast_s) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = row_p_s;
        acc_d = {acc_q[WIDTH-2:0], row_q_s};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          quot_d = {WIDTH{1'b1}};
          rem_d  = neg_n_q ? (W_ZERO - acc_q) : acc_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = (neg_n_q ^ neg_d_q) ? (W_ZERO - acc_q) : acc_q;
          rem_d  = neg_n_q ? (W_ZERO - p_q) : p_q;
          dbz_d  = 1'b0;
          // A positive quotient with its MSB set can only be 2^(WIDTH-1).
          ovf_d  = ~(neg_n_q ^ neg_d_q) & acc_q[WIDTH-1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      p_q     <= W_ZERO;
      acc_q   <= W_ZERO;
      dsr_q   <= W_ZERO;
      neg_n_q <= 1'b0;
      neg_d_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= W_ZERO;
      rem_q   <= W_ZERO;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      neg_n_q <= neg_n_d;
      neg_d_q <= neg_d_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pezaris_seq_divider.sv
// Testbench for pezaris_seq_divider: directed and random operands, an
// arithmetic reference model feeding a scoreboard queue, and an
// independent monitor that checks every done pulse.
module tb_pezaris_seq_divider;

  localparam int W = 7;
  localparam int MINV = -(1 << (W - 1));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           acc;
    int           lat;
    int           a;
    int           b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pezaris_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // Reference: plain signed arithmetic (SV / and % truncate toward zero).
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    int qi, ri;
    e.acc = acc; e.a = a; e.b = b;
    if (b == 0) begin
      qi = -1; ri = a;
      e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 2;
    end else begin
      qi = a / b; ri = a % b;
      e.dbz = 1'b0;
      e.ovf = (a == MINV && b == -1);
      e.lat = W + 2;
`ifdef PEZARIS_DIV_FAST_PATH_EN
      if (a == 0 || b == 1 || b == -1) e.lat = 2;
`endif
    end
    e.q = qi[W-1:0];
    e.r = ri[W-1:0];
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL stray_done: got done=1 at cycle %0d, required no pending result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
          n_fail++;
          $display("FAIL result %0d/%0d: got q=%h r=%h dbz=%b ovf=%b, required q=%h r=%h dbz=%b ovf=%b",
                   e.a, e.b, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        n_tests++;
        if (cyc - e.acc != e.lat) begin
          n_fail++;
          $display("FAIL latency %0d/%0d: got %0d, required %0d", e.a, e.b, cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Called at a negedge: wait for ready, present the operands for one edge.
  task automatic issue(input int a, input int b);
    int waited = 0;
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required 1", waited);
    end else begin
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      sb.push_back(model(a, b, cyc));
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_tests++;
    if ({ready, busy, done, quotient, remainder, div_by_zero, overflow} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, required 1 0 0 00 00 0 0",
               tag, ready, busy, done, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, sel, waited;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset_state");

    // Directed cases (issued back-to-back in each done cycle).
    issue(45, 7);
    issue(-45, 7);
    issue(45, -7);
    issue(-45, -7);
    issue(MINV, -1);
    issue(MINV, 1);
    issue(5, 0);
    issue(10, 3);
    issue(0, 5);
    issue(MINV, 0);

    // start while busy is ignored; held start in the done cycle is taken.
    issue(45, 7);
    repeat (2) @(negedge clk);
    dividend = W'(9); divisor = W'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(9, 2);

    // Reset in the middle of CALC aborts the operation with no done.
    issue(45, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_idle_zero("reset_abort");
    @(negedge clk);
    check_idle_zero("after_abort");
    issue(20, 4);

    // Random operands with extra weight on boundary values.
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1)) + MINV;
      b = int'($urandom_range(0, (1 << W) - 1)) + MINV;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: b = 0;
        1: b = ($urandom_range(0, 1) == 0) ? 1 : -1;
        2: a = MINV;
        3: a = 0;
        default: ;
      endcase
      issue(a, b);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
